// File: rtl/trigger_link_framer.sv
// Trigger link framer: maps cluster groups onto trigger links and emits one
// 4-word 8b10b frame per BX (word0 carries the K char + first payload byte).
// Tracks BX-strobe cadence, inserts a periodic K28.7 latency marker and
// flags overflow with K28.0.
// Optional build macro: TRIGGER_LINK_TEST_PATTERN_EN adds ena_test_pat, which
// swaps the payload for PRBS-7 data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | not locked; idle words (K28.5 + D16.2) every cycle
// ST_RUN   | locked to strobe cadence; phase 0..3 = frame word on output
module trigger_link_framer #(
    parameter int NUM_CLUSTERS      = 8,
    parameter int CLUSTERS_PER_LINK = 4,
    parameter int NUM_LINKS         = 4,
    parameter int FC_PERIOD         = 128
) (
    input  logic                       clk_160,
    input  logic                       reset,
    input  logic                       bx_strobe,
    input  logic [14*NUM_CLUSTERS-1:0] clusters,
    input  logic                       overflow,
`ifdef TRIGGER_LINK_TEST_PATTERN_EN
    input  logic                       ena_test_pat,
`endif
    output logic [16*NUM_LINKS-1:0]    tx_data,
    output logic [2*NUM_LINKS-1:0]     tx_isk,
    output logic                       synced,
    output logic                       ltncy_trig,
    output logic [7:0]                 sync_err_cnt
);

    localparam int NUM_GROUPS = NUM_CLUSTERS / CLUSTERS_PER_LINK;
    localparam int PAY_W      = 14 * CLUSTERS_PER_LINK;
    localparam int CNT_W      = $clog2(FC_PERIOD);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [15:0] IDLE_WORD = 16'h50BC;
    localparam logic [1:0]  IDLE_ISK  = 2'b01;
    localparam logic [7:0]  K28_7     = 8'hFC;
    localparam logic [7:0]  K28_0     = 8'h1C;
    localparam logic [7:0]  K28_5     = 8'hBC;

    logic [0:0]       state;
    logic [1:0]       phase;
    logic [CNT_W-1:0] bx_cnt;
    logic             ovf_pend;
    // byte [7:0] leaves with word0 straight from the inputs, so it is not held
    logic [NUM_GROUPS-1:0][PAY_W-1:8] pay_q;

    logic             in_run;
    logic             missing;
    logic             early;
    logic [CNT_W-1:0] cnt_eff;
    logic             ovf_any;
    logic [7:0]       k_sel;
    logic             ovf_pend_nxt;

    logic [NUM_GROUPS-1:0][PAY_W-1:0] pay_new;
    logic [NUM_GROUPS-1:0][15:0]      grp_data;
    logic [NUM_GROUPS-1:0][1:0]       grp_isk;

    // Cadence classification; a strobe seen in IDLE restarts the BX count at 0
    always_comb begin
        in_run  = (state == ST_RUN);
        missing = in_run && (phase == 2'd3) && !bx_strobe;
        early   = in_run && bx_strobe && (phase != 2'd3);
        cnt_eff = in_run ? bx_cnt : '0;
        ovf_any = ovf_pend | overflow;
    end

    // K char choice; overflow coinciding with the latency marker is deferred
    always_comb begin
        k_sel        = K28_5;
        ovf_pend_nxt = 1'b0;
        if (cnt_eff == '0) begin
            k_sel        = K28_7;
            ovf_pend_nxt = ovf_any;
        end else if (ovf_any) begin
            k_sel        = K28_0;
            ovf_pend_nxt = 1'b0;
        end
    end

`ifdef TRIGGER_LINK_TEST_PATTERN_EN
    logic [6:0]       prbs_q;
    logic [6:0]       prbs_s;
    logic [6:0]       prbs_nxt;
    logic [PAY_W-1:0] prbs_bits;

    // PRBS-7 (x^7+x^6+1): one full frame of payload bits per capture, LSB first
    always_comb begin
        prbs_s    = prbs_q;
        prbs_bits = '0;
        for (int b = 0; b < PAY_W; b++) begin
            prbs_bits[b] = prbs_s[6] ^ prbs_s[5];
            prbs_s       = {prbs_s[5:0], prbs_s[6] ^ prbs_s[5]};
        end
        prbs_nxt = prbs_s;
    end

    // PRBS state advances only when a frame actually uses it
    always_ff @(posedge clk_160) begin
        if (reset) begin
            prbs_q <= 7'h7F;
        end else if (bx_strobe && ena_test_pat) begin
            prbs_q <= prbs_nxt;
        end
    end
`endif

    // Payload selection per cluster group: {c3,c2,c1,c0} or test pattern
    always_comb begin
        pay_new = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            pay_new[g] = clusters[PAY_W*g +: PAY_W];
`ifdef TRIGGER_LINK_TEST_PATTERN_EN
            if (ena_test_pat) begin
                pay_new[g] = prbs_bits;
            end
`endif
        end
    end

    // Next word per group: fresh word0 on any strobe, then held payload words
    always_comb begin
        grp_data = '0;
        grp_isk  = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_data[g] = IDLE_WORD;
            grp_isk[g]  = IDLE_ISK;
            if (bx_strobe) begin
                grp_data[g] = {pay_new[g][7:0], k_sel};
                grp_isk[g]  = 2'b01;
            end else if (in_run && !missing) begin
                grp_isk[g] = 2'b00;
                case (phase)
                    2'd0:    grp_data[g] = pay_q[g][23:8];
                    2'd1:    grp_data[g] = pay_q[g][39:24];
                    2'd2:    grp_data[g] = pay_q[g][55:40];
                    default: begin
                        grp_data[g] = IDLE_WORD;
                        grp_isk[g]  = IDLE_ISK;
                    end
                endcase
            end
        end
    end

    // Framing FSM, counters and registered link outputs
    always_ff @(posedge clk_160) begin
        if (reset) begin
            state        <= ST_IDLE;
            phase        <= 2'd0;
            bx_cnt       <= '0;
            ovf_pend     <= 1'b0;
            pay_q        <= '0;
            synced       <= 1'b0;
            ltncy_trig   <= 1'b0;
            sync_err_cnt <= 8'd0;
            for (int l = 0; l < NUM_LINKS; l++) begin
                tx_data[16*l +: 16] <= IDLE_WORD;
                tx_isk[2*l +: 2]    <= IDLE_ISK;
            end
        end else begin
            if (bx_strobe) begin
                state    <= ST_RUN;
                phase    <= 2'd0;
                bx_cnt   <= cnt_eff + CNT_W'(1);
                ovf_pend <= ovf_pend_nxt;
                for (int g = 0; g < NUM_GROUPS; g++) begin
                    pay_q[g] <= pay_new[g][PAY_W-1:8];
                end
            end else if (missing) begin
                state <= ST_IDLE;
                phase <= 2'd0;
            end else if (in_run) begin
                phase <= phase + 2'd1;
            end

            if ((early || missing) && (sync_err_cnt != 8'hFF)) begin
                sync_err_cnt <= sync_err_cnt + 8'd1;
            end

            synced     <= bx_strobe || (in_run && !missing);
            ltncy_trig <= bx_strobe && (cnt_eff == '0);

            for (int l = 0; l < NUM_LINKS; l++) begin
                tx_data[16*l +: 16] <= grp_data[l % NUM_GROUPS];
                tx_isk[2*l +: 2]    <= grp_isk[l % NUM_GROUPS];
            end
        end
    end

endmodule

// File: tb/tb_trigger_link_framer.sv
// Scoreboard bench for trigger_link_framer (default parameters: 8 clusters,
// 4 links, FC period 128). Stimulus pushes expected per-cycle link state;
// a negedge monitor pops and compares.
module tb_trigger_link_framer;

    logic         clk_160 = 1'b0;
    logic         reset;
    logic         bx_strobe;
    logic [111:0] clusters;
    logic         overflow;
    logic [63:0]  tx_data;
    logic [7:0]   tx_isk;
    logic         synced;
    logic         ltncy_trig;
    logic [7:0]   sync_err_cnt;

    localparam logic [63:0] IDLE_D = {4{16'h50BC}};
    localparam logic [7:0]  IDLE_K = 8'h55;

    trigger_link_framer dut (
        .clk_160      (clk_160),
        .reset        (reset),
        .bx_strobe    (bx_strobe),
        .clusters     (clusters),
        .overflow     (overflow),
`ifdef TRIGGER_LINK_TEST_PATTERN_EN
        .ena_test_pat (1'b0),
`endif
        .tx_data      (tx_data),
        .tx_isk       (tx_isk),
        .synced       (synced),
        .ltncy_trig   (ltncy_trig),
        .sync_err_cnt (sync_err_cnt)
    );

    always #3 clk_160 = ~clk_160;

    int cyc = 0;
    always @(posedge clk_160) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [63:0] d;
        logic [7:0]  k;
        logic        s;
        logic        l;
        logic [7:0]  e;
        int          id;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int id    = 0;

    // bench-side model of the framing state
    bit m_run        = 1'b0;
    int m_bx         = 0;
    bit m_pend       = 1'b0;
    int m_err        = 0;
    bit m_early_next = 1'b0;

    task automatic push(input int off, input logic [63:0] d, input logic [7:0] k,
                        input logic s, input logic l, input int e);
        exp_t x;
        x.cyc = cyc + off;
        x.d   = d;
        x.k   = k;
        x.s   = s;
        x.l   = l;
        x.e   = e[7:0];
        x.id  = id;
        id++;
        q.push_back(x);
    endtask

    // monitor: compare on the falling edge, away from the active edge
    always @(negedge clk_160) begin : monitor
        exp_t x;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            x = q.pop_front();
            total++;
            bad++;
            $display("FAIL stale_expectation id=%0d cyc=%0d never compared", x.id, x.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            x = q.pop_front();
            total++;
            if ({tx_data, tx_isk, synced, ltncy_trig, sync_err_cnt} !== {x.d, x.k, x.s, x.l, x.e}) begin
                bad++;
                $display("FAIL link_state id=%0d cyc=%0d got data=%h isk=%h synced=%b lt=%b err=%0d want data=%h isk=%h synced=%b lt=%b err=%0d",
                         x.id, cyc, tx_data, tx_isk, synced, ltncy_trig, sync_err_cnt,
                         x.d, x.k, x.s, x.l, x.e);
            end
        end
    end

    task automatic step();
        @(posedge clk_160);
        #1;
    endtask

    function automatic logic [15:0] wsel(input logic [55:0] p, input logic [7:0] k, input int w);
        case (w)
            0:       return {p[7:0], k};
            1:       return p[23:8];
            2:       return p[39:24];
            default: return p[55:40];
        endcase
    endfunction

    function automatic logic [111:0] mk(input int i);
        logic [111:0] r;
        logic [31:0]  v;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            v = i * 263 + c * 1187 + 3;
            r[14*c +: 14] = v[13:0];
        end
        return r;
    endfunction

    // Issue one strobe; next strobe follows after gap cycles (gap<4 early, gap>4 missing)
    task automatic bx(input logic [111:0] cl, input logic ovf, input int gap);
        logic [7:0]  k;
        logic        lt;
        logic        any;
        int          cnt;
        logic [15:0] a;
        logic [15:0] b;
        if (m_run && m_early_next) m_err = (m_err < 255) ? m_err + 1 : 255;
        cnt = m_run ? m_bx : 0;
        any = m_pend | ovf;
        lt  = 1'b0;
        if (cnt == 0) begin
            k = 8'hFC; lt = 1'b1; m_pend = any;
        end else if (any) begin
            k = 8'h1C; m_pend = 1'b0;
        end else begin
            k = 8'hBC; m_pend = 1'b0;
        end
        m_bx         = (cnt + 1) % 128;
        m_run        = 1'b1;
        m_early_next = (gap < 4);

        bx_strobe = 1'b1;
        clusters  = cl;
        overflow  = ovf;
        for (int w = 0; w < 4 && w < gap; w++) begin
            a = wsel(cl[55:0], k, w);
            b = wsel(cl[111:56], k, w);
            push(w + 1, {b, a, b, a}, (w == 0) ? 8'h55 : 8'h00, 1'b1, (w == 0) ? lt : 1'b0, m_err);
        end
        if (gap > 4) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_run = 1'b0;
            for (int off = 5; off <= gap; off++) push(off, IDLE_D, IDLE_K, 1'b0, 1'b0, m_err);
        end
        step();
        bx_strobe = 1'b0;
        overflow  = 1'b0;
        clusters  = {$urandom, $urandom, $urandom, $urandom};
        repeat (gap - 1) step();
    endtask

    initial begin
        reset     = 1'b1;
        bx_strobe = 1'b0;
        overflow  = 1'b0;
        clusters  = '0;
        step();
        step();
        push(0, IDLE_D, IDLE_K, 1'b0, 1'b0, 0);
        step();
        reset = 1'b0;
        step();
        push(0, IDLE_D, IDLE_K, 1'b0, 1'b0, 0);
        step();

        // BX0 carries FC + overflow, BX1 sends deferred 1C, BX2 plain BC
        bx({14'd8, 14'd7, 14'd6, 14'd5, 14'd4, 14'd3, 14'd2, 14'd1}, 1'b1, 4);
        bx(mk(1), 1'b0, 4);
        bx(mk(2), 1'b0, 4);
        // BX3..129 (BX128 is the next latency marker)
        for (int i = 3; i < 130; i++) bx(mk(i), 1'b0, 4);

        // early strobe at phase 1, then back to regular cadence
        bx(mk(200), 1'b0, 2);
        bx(mk(201), 1'b0, 4);
        bx(mk(202), 1'b0, 4);

        // missing strobe -> idle, unlocked
        bx(mk(203), 1'b0, 7);

        // relock with a new latency marker, then saturate the error count
        bx(mk(204), 1'b0, 4);
        for (int i = 0; i < 300; i++) bx(mk(300 + i), 1'b0, 2);
        bx(mk(700), 1'b0, 4);
        bx(mk(701), 1'b1, 4);
        bx(mk(702), 1'b0, 4);

        // reset in mid-frame
        bx(mk(7), 1'b0, 2);
        reset = 1'b1;
        push(1, IDLE_D, IDLE_K, 1'b0, 1'b0, 0);
        m_run = 1'b0; m_bx = 0; m_pend = 1'b0; m_err = 0; m_early_next = 1'b0;
        step();
        reset = 1'b0;
        step();
        push(0, IDLE_D, IDLE_K, 1'b0, 1'b0, 0);
        step();
        bx(mk(9), 1'b1, 4);
        bx(mk(10), 1'b0, 5);
        repeat (4) step();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
